// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key-schedule controller: one shared expansion step sequenced over
// NUM_ROUNDS cycles, with an indexed round-key buffer readable as soon as each key lands.
module key_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_key_valid,
  output logic         o_key_ready,
  input  logic [127:0] i_key,
  output logic         o_busy,
  output logic         o_keys_valid,
  input  logic         i_rk_req,
  input  logic [3:0]   i_rk_idx,
  output logic         o_rk_valid,
  output logic [127:0] o_round_key,
  output logic         o_rk_err
);

  localparam int unsigned Depth = NUM_ROUNDS + 1;
  localparam int unsigned IdxW  = $clog2(Depth);
  localparam logic [3:0]  LastRound = 4'(NUM_ROUNDS);

  // Byte x of the S-box lives at bits [{~x, 3'b000} +: 8].
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = {~x, 3'b000};
    return SboxTable[pos +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e         state_q;
  logic [3:0]     wr_cnt_q;
  logic [127:0]   work_q;
  logic [127:0]   key_buf [Depth];
  logic           key_ready_q;

  logic           accept;
  logic           rd_ok;
  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    rot_w, sub_w, t_w;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;

  assign o_key_ready = key_ready_q;
  assign accept      = i_key_valid && key_ready_q;
  // An accept in the same cycle invalidates the buffer, so it always wins over a read.
  assign rd_ok       = i_rk_req && !accept && (i_rk_idx < wr_cnt_q) && (i_rk_idx <= LastRound);

  // Expansion step works from the dedicated working register, never the buffer.
  assign {w0, w1, w2, w3} = work_q;
  assign rot_w    = {w3[23:0], w3[31:24]};
  assign sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
  assign t_w      = sub_w ^ {rcon(wr_cnt_q), 24'h000000};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wr_cnt_q     <= 4'd0;
      work_q       <= 128'd0;
      key_ready_q  <= 1'b1;
      o_busy       <= 1'b0;
      o_keys_valid <= 1'b0;
      o_rk_valid   <= 1'b0;
      o_rk_err     <= 1'b0;
      o_round_key  <= 128'd0;
    end else begin
      o_rk_valid <= rd_ok;
      o_rk_err   <= i_rk_req && !rd_ok;
      if (rd_ok) begin
        o_round_key <= key_buf[i_rk_idx[IdxW-1:0]];
      end
      case (state_q)
        StIdle, StReady: begin
          if (accept) begin
            state_q      <= StExpand;
            wr_cnt_q     <= 4'd1;
            work_q       <= i_key;
            key_ready_q  <= 1'b0;
            o_busy       <= 1'b1;
            o_keys_valid <= 1'b0;
          end
        end
        StExpand: begin
          work_q   <= next_key;
          wr_cnt_q <= wr_cnt_q + 4'd1;
          if (wr_cnt_q == LastRound) begin
            state_q      <= StReady;
            key_ready_q  <= 1'b1;
            o_busy       <= 1'b0;
            o_keys_valid <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Buffer contents are never exposed before being written, so it needs no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      key_buf[0] <= i_key;
    end else if (state_q == StExpand) begin
      key_buf[wr_cnt_q[IdxW-1:0]] <= next_key;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 expansion vectors; a second
// instance built with NUM_ROUNDS=4 covers the reduced-depth configuration.
module tb_key_schedule_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         key_valid, key_ready, busy, keys_valid;
  logic [127:0] key, round_key;
  logic         rk_req, rk_valid, rk_err;
  logic [3:0]   rk_idx;

  logic         key_valid4, key_ready4, busy4, keys_valid4;
  logic [127:0] key4, round_key4;
  logic         rk_req4, rk_valid4, rk_err4;
  logic [3:0]   rk_idx4;

  int errors = 0;
  int checks = 0;

  logic [127:0] rk_a [0:10];
  logic [127:0] key_b, rb1, rb10;

  always #5 clock = ~clock;

  key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
    .clock(clock), .reset(reset),
    .i_key_valid(key_valid), .o_key_ready(key_ready), .i_key(key),
    .o_busy(busy), .o_keys_valid(keys_valid),
    .i_rk_req(rk_req), .i_rk_idx(rk_idx),
    .o_rk_valid(rk_valid), .o_round_key(round_key), .o_rk_err(rk_err)
  );

  key_schedule_ctrl #(.NUM_ROUNDS(4)) dut4 (
    .clock(clock), .reset(reset),
    .i_key_valid(key_valid4), .o_key_ready(key_ready4), .i_key(key4),
    .o_busy(busy4), .o_keys_valid(keys_valid4),
    .i_rk_req(rk_req4), .i_rk_idx(rk_idx4),
    .o_rk_valid(rk_valid4), .o_round_key(round_key4), .o_rk_err(rk_err4)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    key_valid = 0; key = '0; rk_req = 0; rk_idx = '0;
    key_valid4 = 0; key4 = '0; rk_req4 = 0; rk_idx4 = '0;
    tick;
    tick;
    checks++;
    if ({key_ready, busy, keys_valid, rk_valid, rk_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b want %b",
               {key_ready, busy, keys_valid, rk_valid, rk_err}, 5'b10000);
    end
    checks++;
    if (round_key !== 128'd0) begin
      errors++;
      $display("FAIL reset_round_key: got %h want 0", round_key);
    end
    checks++;
    if (key_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut4: got ready=%b busy=%b want 1 0", key_ready4, busy4);
    end
    reset = 1'b1;
    // Nothing written yet, so even index 0 is rejected.
    rk_req = 1; rk_idx = 4'd0;
    tick;
    rk_req = 0;
    checks++;
    if (rk_err !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_read_empty: got err=%b valid=%b want 1 0", rk_err, rk_valid);
    end
  endtask

  task automatic test_expand;
    key = rk_a[0]; key_valid = 1;
    tick;
    key_valid = 0;
    checks++;
    if ({busy, key_ready, keys_valid} !== 3'b100) begin
      errors++;
      $display("FAIL expand_accept: got %b want 100", {busy, key_ready, keys_valid});
    end
    for (int i = 1; i < 10; i++) begin
      tick;
      checks++;
      if (busy !== 1'b1 || keys_valid !== 1'b0) begin
        errors++;
        $display("FAIL expand_busy_%0d: got busy=%b kv=%b want 1 0", i, busy, keys_valid);
      end
    end
    tick;
    checks++;
    if ({busy, key_ready, keys_valid} !== 3'b011) begin
      errors++;
      $display("FAIL expand_done: got %b want 011", {busy, key_ready, keys_valid});
    end
    rk_req = 1; rk_idx = 4'd1;
    tick;
    checks++;
    if (rk_valid !== 1'b1 || rk_err !== 1'b0 || round_key !== rk_a[1]) begin
      errors++;
      $display("FAIL read_a1: got v=%b %h want 1 %h", rk_valid, round_key, rk_a[1]);
    end
    rk_idx = 4'd10;
    tick;
    checks++;
    if (rk_valid !== 1'b1 || round_key !== rk_a[10]) begin
      errors++;
      $display("FAIL read_a10: got v=%b %h want 1 %h", rk_valid, round_key, rk_a[10]);
    end
    rk_idx = 4'd0;
    tick;
    checks++;
    if (rk_valid !== 1'b1 || round_key !== rk_a[0]) begin
      errors++;
      $display("FAIL read_a0: got v=%b %h want 1 %h", rk_valid, round_key, rk_a[0]);
    end
    rk_req = 0;
    tick;
    checks++;
    if (rk_valid !== 1'b0 || rk_err !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: got v=%b err=%b want 0 0", rk_valid, rk_err);
    end
  endtask

  task automatic test_key2;
    key = key_b; key_valid = 1;
    tick;
    key_valid = 0;
    repeat (10) tick;
    rk_req = 1; rk_idx = 4'd1;
    tick;
    checks++;
    if (rk_valid !== 1'b1 || round_key !== rb1) begin
      errors++;
      $display("FAIL read_b1: got v=%b %h want 1 %h", rk_valid, round_key, rb1);
    end
    rk_idx = 4'd10;
    tick;
    rk_req = 0;
    checks++;
    if (rk_valid !== 1'b1 || round_key !== rb10) begin
      errors++;
      $display("FAIL read_b10: got v=%b %h want 1 %h", rk_valid, round_key, rb10);
    end
  endtask

  task automatic test_read_behind;
    key = rk_a[0]; key_valid = 1;
    tick;
    key_valid = 0;
    rk_req = 1; rk_idx = 4'd0;
    for (int j = 1; j <= 11; j++) begin
      tick;
      checks++;
      if (rk_valid !== 1'b1 || rk_err !== 1'b0 || round_key !== rk_a[j-1]) begin
        errors++;
        $display("FAIL behind_%0d: got v=%b %h want 1 %h", j - 1, rk_valid, round_key,
                 rk_a[j-1]);
      end
      rk_idx = 4'(j);
    end
    rk_req = 0;
    // Early read of a not-yet-written key.
    key = rk_a[0]; key_valid = 1;
    tick;
    key_valid = 0;
    tick;
    rk_req = 1; rk_idx = 4'd5;
    tick;
    rk_req = 0;
    checks++;
    if (rk_err !== 1'b1 || rk_valid !== 1'b0 || round_key !== rk_a[10]) begin
      errors++;
      $display("FAIL early_idx5: got err=%b v=%b %h want 1 0 %h", rk_err, rk_valid,
               round_key, rk_a[10]);
    end
    tick;
    checks++;
    if (rk_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got err=%b want 0", rk_err);
    end
    repeat (7) tick;
    rk_req = 1; rk_idx = 4'd11;
    tick;
    checks++;
    if (rk_err !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_idx11: got err=%b v=%b want 1 0", rk_err, rk_valid);
    end
    rk_idx = 4'd15;
    tick;
    rk_req = 0;
    checks++;
    if (rk_err !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_idx15: got err=%b v=%b want 1 0", rk_err, rk_valid);
    end
  endtask

  task automatic test_handshake;
    key = rk_a[0]; key_valid = 1;
    tick;
    key = key_b;
    for (int j = 1; j <= 9; j++) begin
      tick;
      checks++;
      if (key_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_valid_%0d: got ready=%b busy=%b want 0 1", j, key_ready, busy);
      end
    end
    key_valid = 0;
    tick;
    rk_req = 1; rk_idx = 4'd10;
    tick;
    rk_req = 0;
    checks++;
    if (keys_valid !== 1'b1 || round_key !== rk_a[10]) begin
      errors++;
      $display("FAIL hold_ignored: got kv=%b %h want 1 %h", keys_valid, round_key, rk_a[10]);
    end
    // Rekey with a simultaneous read: the accept wins.
    key = key_b; key_valid = 1; rk_req = 1; rk_idx = 4'd3;
    tick;
    key_valid = 0;
    checks++;
    if ({rk_err, rk_valid, busy, keys_valid} !== 4'b1010) begin
      errors++;
      $display("FAIL rekey_collide: got %b want 1010", {rk_err, rk_valid, busy, keys_valid});
    end
    tick;
    rk_req = 0;
    checks++;
    if (rk_err !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL rekey_old_gone: got err=%b v=%b want 1 0", rk_err, rk_valid);
    end
    repeat (9) tick;
    rk_req = 1; rk_idx = 4'd10;
    tick;
    rk_req = 0;
    checks++;
    if (keys_valid !== 1'b1 || rk_valid !== 1'b1 || round_key !== rb10) begin
      errors++;
      $display("FAIL rekey_b10: got kv=%b v=%b %h want 1 1 %h", keys_valid, rk_valid,
               round_key, rb10);
    end
  endtask

  task automatic test_reset_mid;
    key = rk_a[0]; key_valid = 1;
    tick;
    key_valid = 0;
    repeat (3) tick;
    rk_req = 1; rk_idx = 4'd1;
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({key_ready, busy, keys_valid, rk_valid, rk_err} !== 5'b10000) begin
      errors++;
      $display("FAIL async_reset: got %b want 10000",
               {key_ready, busy, keys_valid, rk_valid, rk_err});
    end
    tick;
    checks++;
    if (rk_valid !== 1'b0 || round_key !== 128'd0) begin
      errors++;
      $display("FAIL reset_suppress: got v=%b %h want 0 0", rk_valid, round_key);
    end
    @(negedge clock);
    reset = 1'b1;
    rk_req = 0;
    tick;
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got ready=%b busy=%b kv=%b want 1 0 0", key_ready, busy,
               keys_valid);
    end
    key = key_b; key_valid = 1;
    tick;
    key_valid = 0;
    repeat (10) tick;
    rk_req = 1; rk_idx = 4'd1;
    tick;
    checks++;
    if (rk_valid !== 1'b1 || round_key !== rb1) begin
      errors++;
      $display("FAIL post_reset_b1: got v=%b %h want 1 %h", rk_valid, round_key, rb1);
    end
    rk_idx = 4'd10;
    tick;
    rk_req = 0;
    checks++;
    if (rk_valid !== 1'b1 || round_key !== rb10) begin
      errors++;
      $display("FAIL post_reset_b10: got v=%b %h want 1 %h", rk_valid, round_key, rb10);
    end
  endtask

  task automatic test_rounds4;
    key4 = rk_a[0]; key_valid4 = 1;
    tick;
    key_valid4 = 0;
    repeat (3) tick;
    checks++;
    if (busy4 !== 1'b1 || keys_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL r4_edge3: got busy=%b kv=%b want 1 0", busy4, keys_valid4);
    end
    tick;
    checks++;
    if (busy4 !== 1'b0 || keys_valid4 !== 1'b1 || key_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL r4_done: got busy=%b kv=%b ready=%b want 0 1 1", busy4, keys_valid4,
               key_ready4);
    end
    rk_req4 = 1; rk_idx4 = 4'd4;
    tick;
    checks++;
    if (rk_valid4 !== 1'b1 || round_key4 !== rk_a[4]) begin
      errors++;
      $display("FAIL r4_idx4: got v=%b %h want 1 %h", rk_valid4, round_key4, rk_a[4]);
    end
    rk_idx4 = 4'd5;
    tick;
    checks++;
    if (rk_err4 !== 1'b1 || rk_valid4 !== 1'b0 || round_key4 !== rk_a[4]) begin
      errors++;
      $display("FAIL r4_idx5: got err=%b v=%b %h want 1 0 %h", rk_err4, rk_valid4,
               round_key4, rk_a[4]);
    end
    rk_idx4 = 4'd3;
    tick;
    rk_req4 = 0;
    checks++;
    if (rk_valid4 !== 1'b1 || round_key4 !== rk_a[3]) begin
      errors++;
      $display("FAIL r4_idx3: got v=%b %h want 1 %h", rk_valid4, round_key4, rk_a[3]);
    end
  endtask

  initial begin
    rk_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_b    = 128'h5468617473206d79204b756e67204675;
    rb1      = 128'he232fcf191129188b159e4e6d679a293;
    rb10     = 128'h28fddef86da4244accc0a4fe3b316f26;

    test_reset;
    test_expand;
    test_key2;
    test_read_behind;
    test_handshake;
    test_reset_mid;
    test_rounds4;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Iterative AES-128 key-schedule controller. It accepts one cipher key over a valid/ready handshake. It then drives a single shared key-expansion step for NUM_ROUNDS cycles, producing one round key per cycle, and buffers round keys 0..NUM_ROUNDS. The cipher round datapath reads keys by index; a key is readable as soon as it has been written. The block replaces per-round key_expansion instances with one sequenced unit.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; legal range 1..10; buffer depth is NUM_ROUNDS+1.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
i_key_valid  in  1  cipher key offered
o_key_ready  out  1  controller can accept a key (IDLE or READY)
i_key  in  128  cipher key (block type), MSB = first byte
o_busy  out  1  high while in EXPAND
o_keys_valid  out  1  all NUM_ROUNDS+1 round keys are present
i_rk_req  in  1  round-key read request
i_rk_idx  in  4  requested round index
o_rk_valid  out  1  read data valid, one cycle after an accepted request
o_round_key  out  128  round key for the request
o_rk_err  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset (reset=0): state=IDLE, wr_cnt=0, every output 0 except o_key_ready=1. Buffer contents are don't-care but never exposed.
- States:
  - IDLE -> EXPAND on i_key_valid && o_key_ready.
  - EXPAND -> READY after NUM_ROUNDS cycles.
  - READY -> EXPAND on a new key accept (rekey).
- Accept edge:
  - buf[0] <= i_key; wr_cnt <= 1; o_keys_valid <= 0; o_busy <= 1.
  - i_key is sampled only at this edge.
- EXPAND, cycle k (k=1..NUM_ROUNDS):
  - Step: prev = buf[k-1] = {w0,w1,w2,w3}; t = SubWord(RotWord(w3)) ^ {rcon[k],24'h0}; n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2; buf[k] <= {n0,n1,n2,n3}; wr_cnt <= k+1.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - The S-box is an internal 256-entry combinational table; no external resources.
  - prev comes from a dedicated working register, so the step never reads the buffer combinationally.
- Expansion latency: key k is registered k edges after the accept edge. At edge NUM_ROUNDS: state=READY, o_busy=0, o_keys_valid=1, o_key_ready=1.
- o_key_ready = (state==IDLE || state==READY). It is 0 throughout EXPAND; i_key_valid is ignored there, and the source must hold the key.
- Reads:
  - A request is legal when i_rk_idx < wr_cnt and i_rk_idx <= NUM_ROUNDS, and no key accept happens in the same cycle.
  - Legal request: next cycle o_rk_valid=1 and o_round_key=buf[idx].
  - Illegal request: next cycle o_rk_valid=0, o_rk_err=1, and o_round_key holds its previous value.
  - Reads of already-written keys are legal during EXPAND, so the cipher can run one round behind the expander.
  - Back-to-back requests are allowed every cycle. With no request, o_rk_valid=0 and o_rk_err=0.
- Simultaneous key accept and read request: the accept wins and the read is rejected (o_rk_err).
- Rekey from READY: the old keys become unreadable at the accept edge (wr_cnt=1).
- Reset mid-EXPAND: abort, return to IDLE, o_keys_valid=0. Any read response due in that cycle is suppressed.
- Width rules:
  - wr_cnt is 4 bits and saturates at NUM_ROUNDS+1.
  - An i_rk_idx of 11..15 is always illegal.

Test Plan:
1. Reset, then i_key=2b7e151628aed2a6abf7158809cf4f3c with valid for 1 cycle -> o_busy high for 10 cycles. o_keys_valid=1 exactly 10 edges after accept. Read idx 1 -> a0fafe1788542cb123a339392a6c7605; idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; idx 0 -> the key.
2. Key 5468617473206D79204B756E67204675 -> idx 1 = e232fcf191129188b159e4e6d679a293; idx 10 = 28fddef86da4244accc0a4fe3b316f26.
3. Read-behind during EXPAND: request idx k at cycle k+1 after accept -> valid, correct data. Request idx 5 at cycle 2 -> o_rk_err pulse with o_rk_valid=0. Request idx 11 in READY -> o_rk_err.
4. Handshake: hold i_key_valid high during EXPAND with a different key -> ignored, o_key_ready=0. In READY, rekey with the second key plus a simultaneous read -> read gets o_rk_err; new idx 10 matches scenario 2.
5. Assert reset low at cycle 4 of EXPAND -> all outputs clear asynchronously; IDLE, o_key_ready=1. A fresh key then expands correctly.
6. NUM_ROUNDS=4 build -> o_keys_valid 4 edges after accept; idx 4 = the round-4 FIPS-197 key ef44a541a8525b7fb671253bdb0bad00 (for the key 2b7e…); idx 5 -> o_rk_err.
